// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural fetch PC (word address).
// Selects the next PC from sequential, branch, jump, jump-register or the
// exception vector, holds through stalls while buffering one redirect, and
// keeps fetch invalid during a short post-reset boot window.
// Optional macro PC_SEQ_TRACE_EN adds a 32-bit fetch_count output that
// counts every edge on which a valid PC advances or redirects.
module pc_sequencer #(
    parameter int              PC_W       = 32,
    parameter logic [PC_W-1:0] RESET_VEC  = 32'h0000_0000,
    parameter logic [PC_W-1:0] EXC_VEC    = 32'h0000_0020,
    parameter int              BOOT_DELAY = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            branch_taken,
    input  logic [15:0]     branch_offset,
    input  logic            jump,
    input  logic [25:0]     jump_target,
    input  logic            jump_reg,
    input  logic [PC_W-1:0] reg_target,
    input  logic            exception,
`ifdef PC_SEQ_TRACE_EN
    output logic [31:0]     fetch_count,
`endif
    output logic [PC_W-1:0] pc,
    output logic [PC_W-1:0] pc_plus1,
    output logic            if_valid,
    output logic [PC_W-1:0] epc
);

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    localparam logic [PC_W-1:0] PC_ONE    = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [3:0]      BOOT_LAST = 4'(BOOT_DELAY - 1);

    state_t          state_r;
    logic [3:0]      boot_cnt_r;
    logic [PC_W-1:0] pc_r;
    logic [PC_W-1:0] epc_r;
    logic            if_valid_r;
    logic [PC_W-1:0] pend_target_r;
    logic            pend_valid_r;

    logic [PC_W-1:0] pc_plus1_s;
    logic [PC_W-1:0] branch_addr_s;
    logic [PC_W-1:0] jump_addr_s;
    logic [PC_W-1:0] target_s;
    logic            redirect_s;
    logic            pc_load_s;

    assign pc_plus1_s    = pc_r + PC_ONE;
    assign branch_addr_s = pc_plus1_s + {{(PC_W-16){branch_offset[15]}}, branch_offset};
    assign jump_addr_s   = {pc_plus1_s[PC_W-1:26], jump_target};

    assign pc       = pc_r;
    assign pc_plus1 = pc_plus1_s;
    assign if_valid = if_valid_r;
    assign epc      = epc_r;

    // Priority mux of redirect candidates; falls through to sequential.
    always_comb begin
        redirect_s = exception | jump_reg | jump | branch_taken;
        if (exception) begin
            target_s = EXC_VEC;
        end else if (jump_reg) begin
            target_s = reg_target;
        end else if (jump) begin
            target_s = jump_addr_s;
        end else if (branch_taken) begin
            target_s = branch_addr_s;
        end else begin
            target_s = pc_plus1_s;
        end
    end

    // Sequencer FSM: boot window, run, and stall-hold with redirect buffering.
    // Exceptions bypass stall, so a pending exception can never be buffered and
    // any later redirect may freely overwrite the pending target.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r       <= ST_BOOT;
            boot_cnt_r    <= 4'd0;
            pc_r          <= RESET_VEC;
            epc_r         <= '0;
            if_valid_r    <= 1'b0;
            pend_target_r <= '0;
            pend_valid_r  <= 1'b0;
        end else begin
            case (state_r)
                ST_BOOT: begin
                    boot_cnt_r <= boot_cnt_r + 4'd1;
                    pc_r       <= RESET_VEC;
                    if (boot_cnt_r == BOOT_LAST) begin
                        state_r    <= ST_RUN;
                        if_valid_r <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (exception) begin
                        pc_r  <= EXC_VEC;
                        epc_r <= pc_r;
                    end else if (!stall) begin
                        pc_r <= target_s;
                    end else begin
                        if (redirect_s) begin
                            pend_target_r <= target_s;
                            pend_valid_r  <= 1'b1;
                        end
                        state_r <= ST_HOLD;
                    end
                end
                ST_HOLD: begin
                    if (exception) begin
                        pc_r         <= EXC_VEC;
                        epc_r        <= pc_r;
                        pend_valid_r <= 1'b0;
                        state_r      <= ST_RUN;
                    end else if (!stall) begin
                        if (redirect_s) begin
                            pc_r <= target_s;
                        end else if (pend_valid_r) begin
                            pc_r <= pend_target_r;
                        end else begin
                            pc_r <= pc_plus1_s;
                        end
                        pend_valid_r <= 1'b0;
                        state_r      <= ST_RUN;
                    end else if (redirect_s) begin
                        pend_target_r <= target_s;
                        pend_valid_r  <= 1'b1;
                    end
                end
                default: begin
                    state_r      <= ST_BOOT;
                    boot_cnt_r   <= 4'd0;
                    pc_r         <= RESET_VEC;
                    if_valid_r   <= 1'b0;
                    pend_valid_r <= 1'b0;
                end
            endcase
        end
    end

    // A valid PC moves whenever stall is low or an exception forces it.
    assign pc_load_s = if_valid_r & (exception | ~stall);

`ifdef PC_SEQ_TRACE_EN
    logic [31:0] fetch_count_r;

    // Count every edge on which a valid fetch address advances or redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_count_r <= 32'd0;
        end else if (pc_load_s) begin
            fetch_count_r <= fetch_count_r + 32'd1;
        end
    end

    assign fetch_count = fetch_count_r;
`else
    logic unused_load_s;
    assign unused_load_s = pc_load_s;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed self-checking bench for pc_sequencer (BOOT_DELAY = 2).
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        branch_taken;
    logic [15:0] branch_offset;
    logic        jump;
    logic [25:0] jump_target;
    logic        jump_reg;
    logic [31:0] reg_target;
    logic        exception;
    logic [31:0] pc;
    logic [31:0] pc_plus1;
    logic        if_valid;
    logic [31:0] epc;
`ifdef PC_SEQ_TRACE_EN
    logic [31:0] fetch_count;
`endif

    int n_checks = 0;
    int n_errors = 0;

    pc_sequencer dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_offset(branch_offset),
        .jump         (jump),
        .jump_target  (jump_target),
        .jump_reg     (jump_reg),
        .reg_target   (reg_target),
        .exception    (exception),
`ifdef PC_SEQ_TRACE_EN
        .fetch_count  (fetch_count),
`endif
        .pc           (pc),
        .pc_plus1     (pc_plus1),
        .if_valid     (if_valid),
        .epc          (epc)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        stall         = 1'b0;
        branch_taken  = 1'b0;
        branch_offset = 16'h0000;
        jump          = 1'b0;
        jump_target   = 26'h0;
        jump_reg      = 1'b0;
        reg_target    = 32'h0;
        exception     = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        clear_inputs();
        #3;
        check("rst_pc", pc, 32'h0);
        check("rst_valid", {31'd0, if_valid}, 32'd0);
        check("rst_epc", epc, 32'h0);
        check("rst_plus1", pc_plus1, 32'h1);

        // Release reset; redirects during boot must be ignored.
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        jump_reg   = 1'b1;
        reg_target = 32'h55;
        stall      = 1'b1;
        tick();
        check("boot1_valid", {31'd0, if_valid}, 32'd0);
        check("boot1_pc", pc, 32'h0);
        tick();
        clear_inputs();
        check("boot2_valid", {31'd0, if_valid}, 32'd1);
        check("boot2_pc", pc, 32'h0);
        tick(); check("seq1", pc, 32'h1);
        tick(); check("seq2", pc, 32'h2);
        tick(); check("seq3", pc, 32'h3);

        // Branch / jump redirects.
        jump_reg = 1'b1; reg_target = 32'h10;
        tick(); check("jr_10", pc, 32'h10);
        clear_inputs();
        branch_taken = 1'b1; branch_offset = 16'hFFFC;
        tick(); check("br_back", pc, 32'h0D);
        clear_inputs();
        jump = 1'b1; jump_target = 26'h0000040;
        tick(); check("j_40", pc, 32'h40);
        clear_inputs();

        // Stall, buffer a jump-register, release.
        stall = 1'b1;
        tick(); check("stall0", pc, 32'h40);
        jump_reg = 1'b1; reg_target = 32'h100;
        for (int i = 0; i < 3; i++) begin
            tick(); check("stall_hold", pc, 32'h40);
        end
        clear_inputs();
        tick(); check("pend_rel", pc, 32'h100);

        // Exception beats stall and jump.
        stall = 1'b1; exception = 1'b1; jump = 1'b1; jump_target = 26'h33;
        tick();
        check("exc_pc", pc, 32'h20);
        check("exc_epc", epc, 32'h100);
        check("exc_valid", {31'd0, if_valid}, 32'd1);
        clear_inputs();

        // Priority among simultaneous redirects.
        jump_reg = 1'b1; reg_target = 32'h200; jump = 1'b1; jump_target = 26'h77;
        branch_taken = 1'b1; branch_offset = 16'h0005;
        tick(); check("prio_jr", pc, 32'h200);
        jump_reg = 1'b0; jump_target = 26'h80;
        tick(); check("prio_j", pc, 32'h80);
        clear_inputs();

        // Overwrite pending in HOLD, release with no redirect.
        stall = 1'b1; branch_taken = 1'b1; branch_offset = 16'h0010;
        tick(); check("ow_hold1", pc, 32'h80);
        branch_taken = 1'b0; jump = 1'b1; jump_target = 26'h300;
        tick(); check("ow_hold2", pc, 32'h80);
        clear_inputs();
        tick(); check("ow_rel", pc, 32'h300);

        // Same-cycle redirect at release beats pending.
        stall = 1'b1; jump_reg = 1'b1; reg_target = 32'h400;
        tick(); check("sc_hold", pc, 32'h300);
        clear_inputs();
        branch_taken = 1'b1; branch_offset = 16'h0002;
        tick(); check("sc_rel", pc, 32'h303);
        clear_inputs();
        tick(); check("sc_seq", pc, 32'h304);

        // Exception in HOLD discards pending target.
        stall = 1'b1; jump_reg = 1'b1; reg_target = 32'h500;
        tick(); check("eh_hold", pc, 32'h304);
        jump_reg = 1'b0; exception = 1'b1;
        tick();
        check("eh_pc", pc, 32'h20);
        check("eh_epc", epc, 32'h304);
        clear_inputs();
        tick(); check("eh_seq", pc, 32'h21);

        // Jump keeps the upper bits of pc+1.
        jump_reg = 1'b1; reg_target = 32'h07FF_FFFF;
        tick(); check("jup_set", pc, 32'h07FF_FFFF);
        clear_inputs();
        jump = 1'b1; jump_target = 26'h5;
        tick(); check("jup", pc, 32'h0800_0005);
        clear_inputs();

        // Wrap-around.
        jump_reg = 1'b1; reg_target = 32'hFFFF_FFFF;
        tick();
        check("wrap_set", pc, 32'hFFFF_FFFF);
        check("wrap_plus1", pc_plus1, 32'h0);
        clear_inputs();
        tick(); check("wrap", pc, 32'h0);

        // Reset mid-stall with a pending redirect.
        stall = 1'b1; jump_reg = 1'b1; reg_target = 32'h700;
        tick(); check("mr_hold", pc, 32'h0);
        tick();
        rst_n = 1'b0;
        #1;
        check("mr_pc", pc, 32'h0);
        check("mr_valid", {31'd0, if_valid}, 32'd0);
        check("mr_epc", epc, 32'h0);
        clear_inputs();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        tick();
        tick();
        check("mr_boot_valid", {31'd0, if_valid}, 32'd1);
        check("mr_boot_pc", pc, 32'h0);
`ifdef PC_SEQ_TRACE_EN
        check("fc_zero", fetch_count, 32'd0);
`endif
        // Five sequential advances, then two stalled cycles.
        for (int i = 0; i < 5; i++) tick();
        check("lost_pend", pc, 32'h5);
        stall = 1'b1;
        tick();
        tick();
        check("fc_pc", pc, 32'h5);
`ifdef PC_SEQ_TRACE_EN
        check("fc_five", fetch_count, 32'd5);
`endif
        clear_inputs();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
